// File: rtl/aes_noc_loader.sv
// NOC front end for the AES peripheral: key/IV loading, plaintext block
// assembly into a show-ahead FIFO, and result serialisation onto the NOC.
module aes_noc_loader #(
    parameter int         WORD_W     = 64,
    parameter int         BLOCK_W    = 128,
    parameter int         RK_WORDS   = 22,
    parameter int         FIFO_DEPTH = 4,
    parameter logic [7:0] TX_CMD     = 8'hEF
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [WORD_W-1:0]            rx_data,
    input  logic [7:0]                   rx_cmd,
    input  logic                         rx_valid,
    output logic                         rx_rdy,
    output logic [WORD_W-1:0]            tx_data,
    output logic [7:0]                   tx_cmd,
    output logic                         tx_valid,
    input  logic                         tx_rdy,
    output logic [RK_WORDS*WORD_W-1:0]   rk_out,
    output logic                         rk_loaded,
    output logic [BLOCK_W-1:0]           iv_out,
    output logic                         iv_loaded,
    output logic [BLOCK_W-1:0]           blk_data,
    output logic                         blk_valid,
    input  logic                         blk_ready,
    input  logic [BLOCK_W-1:0]           res_data,
    input  logic                         res_valid,
    output logic                         res_ready,
    output logic [7:0]                   err_count
);

    localparam int WPB = BLOCK_W / WORD_W;
    localparam int RKW = $clog2(RK_WORDS + 1);
    localparam int IVW = $clog2(WPB + 1);
    localparam int AIW = (WPB > 1) ? $clog2(WPB) : 1;
    localparam int AW  = $clog2(FIFO_DEPTH);

    localparam logic [RKW-1:0] RK_FULL  = RKW'(RK_WORDS);
    localparam logic [IVW-1:0] IV_FULL  = IVW'(WPB);
    localparam logic [AIW-1:0] LAST_WRD = AIW'(WPB - 1);

    typedef enum logic {S_IDLE, S_SEND} tx_state_e;

    logic [RK_WORDS*WORD_W-1:0] rk_q, rk_d;
    logic [RKW-1:0]             rk_idx_q, rk_idx_d;
    logic [BLOCK_W-1:0]         iv_q, iv_d;
    logic [IVW-1:0]             iv_idx_q, iv_idx_d;
    logic [BLOCK_W-1:0]         asm_q, asm_d;
    logic [AIW-1:0]             asm_idx_q, asm_idx_d;
    logic [7:0]                 err_q, err_d;
    logic [AW:0]                wr_ptr_q, wr_ptr_d;
    logic [AW:0]                rd_ptr_q, rd_ptr_d;
    logic [BLOCK_W-1:0]         mem_q [FIFO_DEPTH];

    tx_state_e                  state_q, state_d;
    logic [BLOCK_W-1:0]         tx_buf_q, tx_buf_d;
    logic [AIW-1:0]             tx_idx_q, tx_idx_d;
    logic [WORD_W-1:0]          tx_data_q, tx_data_d;
    logic [7:0]                 tx_cmd_q, tx_cmd_d;
    logic                       tx_valid_q, tx_valid_d;

    logic fifo_full, fifo_empty;
    logic accept, push, pop, clear, drop;

    // Extra pointer MSB separates full from empty when the indices match.
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign rx_rdy    = !reset && !(fifo_full && asm_idx_q == LAST_WRD);
    assign accept    = rx_valid && rx_rdy;
    assign pop       = !fifo_empty && blk_ready;

    assign blk_valid = !fifo_empty;
    assign blk_data  = mem_q[rd_ptr_q[AW-1:0]];
    assign rk_out    = rk_q;
    assign iv_out    = iv_q;
    assign rk_loaded = (rk_idx_q == RK_FULL);
    assign iv_loaded = (iv_idx_q == IV_FULL);
    assign err_count = err_q;
    assign tx_data   = tx_data_q;
    assign tx_cmd    = tx_cmd_q;
    assign tx_valid  = tx_valid_q;

    always_comb begin
        rk_d      = rk_q;
        rk_idx_d  = rk_idx_q;
        iv_d      = iv_q;
        iv_idx_d  = iv_idx_q;
        asm_d     = asm_q;
        asm_idx_d = asm_idx_q;
        err_d     = err_q;
        push      = 1'b0;
        clear     = 1'b0;
        drop      = 1'b0;
        if (accept) begin
            case (rx_cmd)
                8'h00: begin
                    if (rk_idx_q == RK_FULL) begin
                        drop = 1'b1;
                    end else begin
                        for (int i = 0; i < RK_WORDS; i++)
                            if (rk_idx_q == RKW'(i))
                                rk_d[i*WORD_W +: WORD_W] = rx_data;
                        rk_idx_d = rk_idx_q + 1'b1;
                    end
                end
                8'h01: begin
                    if (iv_idx_q == IV_FULL) begin
                        drop = 1'b1;
                    end else begin
                        for (int i = 0; i < WPB; i++)
                            if (iv_idx_q == IVW'(i))
                                iv_d[i*WORD_W +: WORD_W] = rx_data;
                        iv_idx_d = iv_idx_q + 1'b1;
                    end
                end
                8'h02: begin
                    for (int i = 0; i < WPB; i++)
                        if (asm_idx_q == AIW'(i))
                            asm_d[i*WORD_W +: WORD_W] = rx_data;
                    if (asm_idx_q == LAST_WRD) begin
                        push      = 1'b1;
                        asm_idx_d = '0;
                    end else begin
                        asm_idx_d = asm_idx_q + 1'b1;
                    end
                end
                8'h03: begin
                    clear     = 1'b1;
                    rk_idx_d  = '0;
                    iv_idx_d  = '0;
                    asm_idx_d = '0;
                end
                default: drop = 1'b1;
            endcase
        end
        if (drop && err_q != 8'hFF)
            err_d = err_q + 8'd1;
    end

    // A clear discards the FIFO even if the core pops in the same cycle.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_ptr_q[AW-1:0]] <= asm_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rk_q      <= '0;
            rk_idx_q  <= '0;
            iv_q      <= '0;
            iv_idx_q  <= '0;
            asm_q     <= '0;
            asm_idx_q <= '0;
            err_q     <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
        end else begin
            rk_q      <= rk_d;
            rk_idx_q  <= rk_idx_d;
            iv_q      <= iv_d;
            iv_idx_q  <= iv_idx_d;
            asm_q     <= asm_d;
            asm_idx_q <= asm_idx_d;
            err_q     <= err_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            tx_buf_q   <= '0;
            tx_idx_q   <= '0;
            tx_data_q  <= '0;
            tx_cmd_q   <= '0;
            tx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_buf_q   <= tx_buf_d;
            tx_idx_q   <= tx_idx_d;
            tx_data_q  <= tx_data_d;
            tx_cmd_q   <= tx_cmd_d;
            tx_valid_q <= tx_valid_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        tx_buf_d   = tx_buf_q;
        tx_idx_d   = tx_idx_q;
        tx_data_d  = tx_data_q;
        tx_cmd_d   = tx_cmd_q;
        tx_valid_d = tx_valid_q;
        unique case (state_q)
            S_IDLE: begin
                if (res_valid && res_ready) begin
                    state_d    = S_SEND;
                    tx_buf_d   = res_data;
                    tx_idx_d   = '0;
                    tx_data_d  = res_data[WORD_W-1:0];
                    tx_cmd_d   = TX_CMD;
                    tx_valid_d = 1'b1;
                end
            end
            S_SEND: begin
                if (tx_rdy) begin
                    if (tx_idx_q == LAST_WRD) begin
                        state_d    = S_IDLE;
                        tx_valid_d = 1'b0;
                    end else begin
                        tx_idx_d = tx_idx_q + 1'b1;
                        for (int i = 0; i < WPB; i++)
                            if (tx_idx_d == AIW'(i))
                                tx_data_d = tx_buf_q[i*WORD_W +: WORD_W];
                    end
                end
            end
        endcase
    end

    always_comb begin
        res_ready = !reset && (state_q == S_IDLE);
    end

endmodule

// File: doc/aes_noc_loader.md
Name: aes_noc_loader

Overview:
- Parametrised NOC16 front end for the AES peripheral.
- Loads round-key and IV words from the NOC receive channel.
- Assembles plaintext data words into cipher blocks and buffers them in a FIFO for the cipher core.
- Serialises result blocks from the core back onto the NOC transmit channel.

Parameters:
- WORD_W, 64: NOC payload width in bits.
- BLOCK_W, 128: cipher block width in bits; must be a multiple of WORD_W. WPB = BLOCK_W/WORD_W.
- RK_WORDS, 22: number of WORD_W round-key words (176 bytes at defaults).
- FIFO_DEPTH, 4: input block FIFO entries; power of two, at least 2.
- TX_CMD, 8'hEF: command byte attached to every transmitted word.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- rx_data  in  WORD_W  NOC receive payload.
- rx_cmd  in  8  NOC receive command.
- rx_valid  in  1  receive word valid.
- rx_rdy  out  1  receive word accepted when rx_valid && rx_rdy.
- tx_data  out  WORD_W  NOC transmit payload.
- tx_cmd  out  8  NOC transmit command.
- tx_valid  out  1  transmit word valid.
- tx_rdy  in  1  transmit word accepted.
- rk_out  out  RK_WORDS*WORD_W  round-key store.
- rk_loaded  out  1  all RK_WORDS key words received.
- iv_out  out  BLOCK_W  IV store.
- iv_loaded  out  1  all WPB IV words received.
- blk_data  out  BLOCK_W  FIFO head block.
- blk_valid  out  1  FIFO non-empty.
- blk_ready  in  1  core pops the head block.
- res_data  in  BLOCK_W  result block from core.
- res_valid  in  1  result block valid.
- res_ready  out  1  result block accepted.
- err_count  out  8  dropped-word counter, saturating at 255.

Behaviour:
- Reset: rk_out, iv_out, tx_data, tx_cmd = 0; tx_valid, rk_loaded, iv_loaded = 0; err_count = 0.
  - rk_idx, iv_idx and asm_idx (data-word assembly index) are zeroed; FIFO is emptied.
  - rx_rdy and res_ready are forced 0 while reset is high.
  - Reset asserted mid-operation aborts any partial block and any in-flight transmit; no word is emitted afterwards.
- Word order: word k of a multi-word item occupies bits [WORD_W*k +: WORD_W]; word 0 arrives or departs first.
- rx_rdy = !(fifo_full && asm_idx == WPB-1). It depends on state only. Key, IV and other commands still flow while the FIFO is full, until a block's last data word must be pushed.
- Accepted words are decoded by rx_cmd; the update is visible the next cycle:
  - 0x00: write rk word rk_idx, then rk_idx++. If rk_idx == RK_WORDS, drop the word and increment err_count. rk_loaded = (rk_idx == RK_WORDS).
  - 0x01: write iv word iv_idx, then iv_idx++. Full IV is handled like full rk (drop, increment err_count). iv_loaded = (iv_idx == WPB).
  - 0x02: write assembly word asm_idx. When asm_idx == WPB-1, push the assembled block into the FIFO and set asm_idx = 0; otherwise asm_idx++.
  - 0x03: clear rk_idx, iv_idx, asm_idx, both loaded flags, and the FIFO. rk_out and iv_out contents are retained. err_count is unchanged.
  - any other command: drop the word and increment err_count.
- err_count saturates at 255.
- Block FIFO:
  - Show-ahead: blk_data = head entry, blk_valid = !empty. A pop occurs on blk_valid && blk_ready.
  - Push and pop in the same cycle are legal when non-empty; occupancy is unchanged.
  - Pointers wrap modulo FIFO_DEPTH; a full/empty flag or an extra pointer bit distinguishes the two states.
  - A 0x03 clear in the same cycle as a pop: the clear wins.
- Transmit serialiser, states IDLE and SEND:
  - IDLE: res_ready = 1. On res_valid, latch res_data and go to SEND with word 0 on tx_data, tx_cmd = TX_CMD, tx_valid = 1 from the next cycle.
  - SEND: res_ready = 0. tx_data and tx_cmd are held stable while tx_valid && !tx_rdy. On tx_rdy, advance to the next word. After the last word is accepted, tx_valid = 0 and the state returns to IDLE (res_ready = 1 the next cycle).
  - Minimum result-to-result period is WPB+1 cycles.

Test Plan:
- Reset, then 22 cmd-0 words 0x1..0x16 → rk_loaded rises the cycle after word 22; rk_out[63:0] = 0x1, rk_out[1407:1344] = 0x16. A 23rd cmd-0 word → err_count = 1, rk_out unchanged.
- Two cmd-1 words 0xAAAA, 0xBBBB → iv_out = {0xBBBB, 0xAAAA}, iv_loaded = 1. Then cmd 0x03 → iv_loaded = 0, iv_out retained.
- Eight cmd-2 words with blk_ready = 0 → FIFO full after 4 blocks. A 9th word is accepted (asm_idx 1); rx_rdy stays 0 for the 10th until one blk_ready pulse. Blocks pop in order; block 0 = {word1, word0}.
- res_data = {0x2222, 0x1111} with tx_rdy toggling 0/1 → tx sees 0x1111 then 0x2222 with cmd 0xEF, each held stable until accepted. res_ready = 0 throughout.
- 300 words with cmd 0x7 → err_count = 255 (saturated), rx_rdy = 1 throughout.
- Reset asserted mid-SEND after word 0 → tx_valid = 0 the next cycle; no further words; FIFO empty; res_ready = 1 after reset deasserts.
